// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable symbol-sequence detector.
package seq_det_pkg;

    localparam logic MODE_RUN   = 1'b0;
    localparam logic MODE_EXACT = 1'b1;

    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Element k of the reset pattern: (k+1) mod 2^sym_w
    function automatic int unsigned reset_sym(input int unsigned k, input int unsigned sym_w);
        return (sym_w >= 32) ? (k + 1) : ((k + 1) % (32'd1 << sym_w));
    endfunction

    function automatic int unsigned reset_len(input int unsigned max_len);
        return (max_len < 3) ? max_len : 3;
    endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Symbol stream, configuration and status bundle of the sequence detector.
interface seq_detector_if
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned MAX_LEN = 4,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic                       valid;
    logic [SYM_W-1:0]           sym;
    logic                       cfg_we;
    logic [MAX_LEN*SYM_W-1:0]   cfg_pattern;
    logic [LEN_W-1:0]           cfg_len;
    logic                       cfg_mode;
    logic                       cfg_overlap;
    logic                       hit;
    logic [CNT_W-1:0]           match_cnt;
    logic [LEN_W-1:0]           progress;

    modport master (
        output valid, sym, cfg_we, cfg_pattern, cfg_len, cfg_mode, cfg_overlap,
        input  hit, match_cnt, progress
    );

    modport slave (
        input  valid, sym, cfg_we, cfg_pattern, cfg_len, cfg_mode, cfg_overlap,
        output hit, match_cnt, progress
    );

endinterface

// File: rtl/seq_det_window.sv
// Exact-mode window: history of recent symbols, saturating fill count and
// a len-masked comparison of the newest len symbols against the pattern.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned MAX_LEN = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clr,
    input  logic                          i_shift,
    input  logic [SYM_W-1:0]              i_sym,
    input  logic [MAX_LEN*SYM_W-1:0]      i_pat,
    input  logic [len_w(MAX_LEN)-1:0]     i_len,
    input  logic                          i_overlap,
    output logic                          o_match_c,
    output logic [len_w(MAX_LEN)-1:0]     o_fill_nxt_c
);
    localparam int unsigned LEN_W  = len_w(MAX_LEN);
    localparam int unsigned HIST_D = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;

    logic [SYM_W-1:0] r_hist [HIST_D];
    logic [LEN_W-1:0] r_fill;

    logic [SYM_W-1:0] w_hist_nxt [MAX_LEN];
    logic [LEN_W-1:0] w_fill_inc;
    logic             w_eq;
    logic             w_match;

    // Window as it would look with the incoming symbol at index 0 (newest)
    always_comb begin
        w_hist_nxt[0] = i_sym;
        for (int unsigned j = 1; j < MAX_LEN; j++) begin
            w_hist_nxt[j] = r_hist[j-1];
        end
        w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);

        // newest symbol pairs with pat[len-1], oldest relevant with pat[0]
        w_eq = 1'b1;
        for (int unsigned j = 0; j < MAX_LEN; j++) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                if ((j + k + 1) == 32'(i_len)) begin
                    if (w_hist_nxt[j] != i_pat[k*SYM_W +: SYM_W]) begin
                        w_eq = 1'b0;
                    end
                end
            end
        end

        w_match = i_shift && (i_len != '0) && (w_fill_inc >= i_len) && w_eq;

        o_fill_nxt_c = r_fill;
        if (i_shift) begin
            o_fill_nxt_c = (w_match && !i_overlap) ? '0 : w_fill_inc;
        end
        o_match_c = w_match;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '{default: '0};
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '{default: '0};
            r_fill <= '0;
        end else if (i_shift) begin
            for (int unsigned j = 0; j < HIST_D; j++) begin
                r_hist[j] <= w_hist_nxt[j];
            end
            r_fill <= o_fill_nxt_c;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Programmable symbol-sequence detector: config registers, run-mode FSM,
// exact-mode window, registered hit and saturating match counter.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned MAX_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    seq_detector_if.slave  bus
);
    localparam int unsigned LEN_W = len_w(MAX_LEN);

    localparam logic [LEN_W-1:0] ST_IDLE  = LEN_W'(0);
    localparam logic [LEN_W-1:0] ST_FIRST = LEN_W'(1);

    logic [MAX_LEN*SYM_W-1:0] r_pat;
    logic [LEN_W-1:0]         r_len;
    logic                     r_mode;
    logic                     r_overlap;
    logic [LEN_W-1:0]         r_state;
    logic                     r_hit;
    logic [CNT_W-1:0]         r_cnt;
    logic [LEN_W-1:0]         r_progress;

    logic                     w_take;
    logic                     w_take_run;
    logic                     w_take_exact;
    logic [SYM_W-1:0]         w_cur;
    logic [SYM_W-1:0]         w_prev;
    logic [LEN_W-1:0]         w_state_nxt;
    logic                     w_hit_nxt;
    logic [LEN_W-1:0]         w_progress_nxt;
    logic [LEN_W-1:0]         w_cfg_len;
    logic                     w_match;
    logic [LEN_W-1:0]         w_fill_nxt;

    seq_det_window #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN)
    ) u_window (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (bus.cfg_we),
        .i_shift      (w_take_exact),
        .i_sym        (bus.sym),
        .i_pat        (r_pat),
        .i_len        (r_len),
        .i_overlap    (r_overlap),
        .o_match_c    (w_match),
        .o_fill_nxt_c (w_fill_nxt)
    );

    // Next-state and hit decode; cfg_we suppresses the symbol in the same cycle
    always_comb begin
        w_take       = bus.valid && !bus.cfg_we && (r_len != '0);
        w_take_run   = w_take && (r_mode == MODE_RUN);
        w_take_exact = w_take && (r_mode == MODE_EXACT);

        w_cur  = '0;
        w_prev = '0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (32'(r_state) == k)     w_cur  = r_pat[k*SYM_W +: SYM_W];
            if (32'(r_state) == k + 1) w_prev = r_pat[k*SYM_W +: SYM_W];
        end

        w_state_nxt = r_state;
        if (w_take_run) begin
            if ((r_state < r_len) && (bus.sym == w_cur)) begin
                w_state_nxt = r_state + LEN_W'(1);
            end else if ((r_state != ST_IDLE) && (bus.sym == w_prev)) begin
                w_state_nxt = r_state;
            end else if (bus.sym == r_pat[SYM_W-1:0]) begin
                w_state_nxt = ST_FIRST;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end

        w_hit_nxt = 1'b0;
        if (w_take_run)   w_hit_nxt = (w_state_nxt == r_len);
        if (w_take_exact) w_hit_nxt = w_match;

        w_progress_nxt = (r_mode == MODE_EXACT) ? w_fill_nxt : w_state_nxt;

        w_cfg_len = (32'(bus.cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cfg_len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                r_pat[k*SYM_W +: SYM_W] <= SYM_W'(reset_sym(k, SYM_W));
            end
            r_len      <= LEN_W'(reset_len(MAX_LEN));
            r_mode     <= MODE_RUN;
            r_overlap  <= 1'b1;
            r_state    <= ST_IDLE;
            r_hit      <= 1'b0;
            r_cnt      <= '0;
            r_progress <= '0;
        end else if (bus.cfg_we) begin
            r_pat      <= bus.cfg_pattern;
            r_len      <= w_cfg_len;
            r_mode     <= bus.cfg_mode;
            r_overlap  <= bus.cfg_overlap;
            r_state    <= ST_IDLE;
            r_hit      <= 1'b0;
            r_cnt      <= '0;
            r_progress <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hit      <= w_hit_nxt;
            r_progress <= w_progress_nxt;
            if (r_hit && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.hit       = r_hit;
    assign bus.match_cnt = r_cnt;
    assign bus.progress  = r_progress;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default and CNT_W=2 instances share one stimulus stream.
module tb_seq_detector;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    seq_detector_if #(.SYM_W(2), .MAX_LEN(4), .CNT_W(8)) bus  ();
    seq_detector_if #(.SYM_W(2), .MAX_LEN(4), .CNT_W(2)) bus2 ();

    assign bus2.valid       = bus.valid;
    assign bus2.sym         = bus.sym;
    assign bus2.cfg_we      = bus.cfg_we;
    assign bus2.cfg_pattern = bus.cfg_pattern;
    assign bus2.cfg_len     = bus.cfg_len;
    assign bus2.cfg_mode    = bus.cfg_mode;
    assign bus2.cfg_overlap = bus.cfg_overlap;

    seq_detector #(.SYM_W(2), .MAX_LEN(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_detector #(.SYM_W(2), .MAX_LEN(4), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.valid  = v;
        bus.sym    = s;
        @(posedge clk);
        #1;
    endtask

    // One valid symbol, then check hit and progress
    task automatic sp(input logic [1:0] s, input logic eh, input logic [2:0] ep, input string tag);
        step(1'b1, s);
        chk({tag, ".hit"}, 32'(bus.hit), 32'(eh));
        chk({tag, ".prog"}, 32'(bus.progress), 32'(ep));
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [2:0] len, input logic mode,
                       input logic ov, input logic v, input logic [1:0] s);
        @(negedge clk);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_mode    = mode;
        bus.cfg_overlap = ov;
        bus.valid       = v;
        bus.sym         = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.valid       = 1'b0;
        bus.sym         = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hit", 32'(bus.hit), 32'd0);
        chk("rst.cnt", 32'(bus.match_cnt), 32'd0);
        chk("rst.prog", 32'(bus.progress), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // legacy 1,2,3 with repeats
        sp(2'd1, 1'b0, 3'd1, "leg1");
        sp(2'd1, 1'b0, 3'd1, "leg2");
        sp(2'd2, 1'b0, 3'd2, "leg3");
        sp(2'd2, 1'b0, 3'd2, "leg4");
        sp(2'd3, 1'b1, 3'd3, "leg5");
        sp(2'd3, 1'b1, 3'd3, "leg6");
        sp(2'd0, 1'b0, 3'd0, "leg7");
        chk("leg.cnt", 32'(bus.match_cnt), 32'd2);

        // run-mode restart
        cfg(8'h39, 3'd3, MODE_RUN, 1'b1, 1'b0, 2'd0);
        chk("rs.cfg.cnt", 32'(bus.match_cnt), 32'd0);
        sp(2'd1, 1'b0, 3'd1, "rs1");
        sp(2'd2, 1'b0, 3'd2, "rs2");
        sp(2'd1, 1'b0, 3'd1, "rs3");
        sp(2'd2, 1'b0, 3'd2, "rs4");
        sp(2'd3, 1'b1, 3'd3, "rs5");
        step(1'b0, 2'd0);
        chk("rs.idle.hit", 32'(bus.hit), 32'd0);
        chk("rs.idle.prog", 32'(bus.progress), 32'd3);
        chk("rs.cnt", 32'(bus.match_cnt), 32'd1);

        // exact mode, overlap on
        cfg(8'h2A, 3'd3, MODE_EXACT, 1'b1, 1'b0, 2'd0);
        sp(2'd2, 1'b0, 3'd1, "ex1");
        sp(2'd2, 1'b0, 3'd2, "ex2");
        sp(2'd2, 1'b1, 3'd3, "ex3");
        sp(2'd2, 1'b1, 3'd4, "ex4");
        sp(2'd2, 1'b1, 3'd4, "ex5");
        step(1'b0, 2'd0);
        chk("ex.idle.hit", 32'(bus.hit), 32'd0);
        chk("ex.cnt", 32'(bus.match_cnt), 32'd3);

        // exact mode, overlap off
        cfg(8'h2A, 3'd3, MODE_EXACT, 1'b0, 1'b0, 2'd0);
        sp(2'd2, 1'b0, 3'd1, "nx1");
        sp(2'd2, 1'b0, 3'd2, "nx2");
        sp(2'd2, 1'b1, 3'd0, "nx3");
        sp(2'd2, 1'b0, 3'd1, "nx4");
        sp(2'd2, 1'b0, 3'd2, "nx5");
        step(1'b0, 2'd0);
        chk("nx.cnt", 32'(bus.match_cnt), 32'd1);

        // valid gaps, then cfg_we beating a valid symbol while hit is high
        cfg(8'h39, 3'd3, MODE_RUN, 1'b1, 1'b0, 2'd0);
        sp(2'd1, 1'b0, 3'd1, "gp1");
        step(1'b0, 2'd2);
        chk("gp.idle.prog", 32'(bus.progress), 32'd1);
        sp(2'd2, 1'b0, 3'd2, "gp2");
        step(1'b0, 2'd3);
        step(1'b0, 2'd3);
        chk("gp.idle2.hit", 32'(bus.hit), 32'd0);
        sp(2'd3, 1'b1, 3'd3, "gp3");
        cfg(8'h39, 3'd3, MODE_RUN, 1'b1, 1'b1, 2'd1);
        chk("pri.hit", 32'(bus.hit), 32'd0);
        chk("pri.prog", 32'(bus.progress), 32'd0);
        chk("pri.cnt", 32'(bus.match_cnt), 32'd0);
        sp(2'd2, 1'b0, 3'd0, "pri.next");

        // cfg_len above MAX_LEN clamps to 4 (pattern 1,2,3,0)
        cfg(8'h39, 3'd7, MODE_RUN, 1'b1, 1'b0, 2'd0);
        sp(2'd1, 1'b0, 3'd1, "cl1");
        sp(2'd2, 1'b0, 3'd2, "cl2");
        sp(2'd3, 1'b0, 3'd3, "cl3");
        sp(2'd0, 1'b1, 3'd4, "cl4");
        sp(2'd0, 1'b1, 3'd4, "cl5");
        sp(2'd1, 1'b0, 3'd1, "cl6");

        // len 0 disables matching in both modes
        cfg(8'h39, 3'd0, MODE_RUN, 1'b1, 1'b0, 2'd0);
        sp(2'd1, 1'b0, 3'd0, "z1");
        sp(2'd2, 1'b0, 3'd0, "z2");
        sp(2'd3, 1'b0, 3'd0, "z3");
        cfg(8'h2A, 3'd0, MODE_EXACT, 1'b1, 1'b0, 2'd0);
        sp(2'd2, 1'b0, 3'd0, "zx1");
        sp(2'd2, 1'b0, 3'd0, "zx2");

        // five hit cycles: 8-bit counter reaches 5, 2-bit counter sticks at 3
        cfg(8'h39, 3'd3, MODE_RUN, 1'b1, 1'b0, 2'd0);
        sp(2'd1, 1'b0, 3'd1, "sat1");
        sp(2'd2, 1'b0, 3'd2, "sat2");
        sp(2'd3, 1'b1, 3'd3, "sat3");
        sp(2'd3, 1'b1, 3'd3, "sat4");
        sp(2'd3, 1'b1, 3'd3, "sat5");
        sp(2'd3, 1'b1, 3'd3, "sat6");
        sp(2'd3, 1'b1, 3'd3, "sat7");
        step(1'b0, 2'd0);
        chk("sat.cnt8", 32'(bus.match_cnt), 32'd5);
        chk("sat.cnt2", 32'(bus2.match_cnt), 32'd3);
        step(1'b0, 2'd0);
        chk("sat.cnt2.hold", 32'(bus2.match_cnt), 32'd3);

        // asynchronous reset mid-stream restores the 1,2,3 run configuration
        cfg(8'h2A, 3'd3, MODE_EXACT, 1'b1, 1'b0, 2'd0);
        sp(2'd2, 1'b0, 3'd1, "ar0");
        #2;
        reset = 1'b1;
        #1;
        chk("ar.hit", 32'(bus.hit), 32'd0);
        chk("ar.prog", 32'(bus.progress), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sp(2'd1, 1'b0, 3'd1, "ar1");
        sp(2'd2, 1'b0, 3'd2, "ar2");
        sp(2'd3, 1'b1, 3'd3, "ar3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
